// File: rtl/pll_drp_ctrl_if.sv
// pll_drp_ctrl_if: request/response bus between a register-bank master and
// the PLL DRP reconfiguration controller.
//   req_*  : single read or masked-write request (valid/ready handshake)
//   rsp_*  : one-cycle completion pulse with read/written data and error flag
interface pll_drp_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_last;
  logic [4:0]  req_addr;
  logic [15:0] req_data;
  logic [15:0] req_mask;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_last, req_addr, req_data, req_mask,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_last, req_addr, req_data, req_mask,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/pll_drp_ctrl.sv
// pll_drp_ctrl: sequences PLL_ADV DRP read / read-modify-write cycles.
// A write burst holds the PLL in reset; the last write of the burst releases
// it after RST_HOLD cycles and waits for (synchronized) lock before completing.
// Ports:
//   sys_clk, sys_rst      : clock (not from the PLL being retuned), sync high reset
//   bus (slave)           : request / response bus
//   busy                  : FSM not idle or PLL held in reset
//   drp_daddr/di/den/dwe  : registered DRP drive
//   drp_do, drp_drdy      : DRP return
//   pll_rst, pll_locked   : PLL reset out, asynchronous lock in
module pll_drp_ctrl #(
  parameter int LOCK_TIMEOUT = 65535,
  parameter int RST_HOLD     = 4,     // must be >= 2
  parameter int DRDY_TIMEOUT = 63
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  pll_drp_ctrl_if.slave bus,
  output logic        busy,
  output logic [4:0]  drp_daddr,
  output logic [15:0] drp_di,
  output logic        drp_den,
  output logic        drp_dwe,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        pll_rst,
  input  logic        pll_locked
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD       = 3'd1;
  localparam logic [2:0] S_MOD      = 3'd2;
  localparam logic [2:0] S_WR       = 3'd3;
  localparam logic [2:0] S_HOLD     = 3'd4;
  localparam logic [2:0] S_LOCKWAIT = 3'd5;
  localparam logic [2:0] S_RESP     = 3'd6;

  logic [2:0]       state_q, state_d;
  logic             we_q, we_d;
  logic             last_q, last_d;
  logic [4:0]       addr_q, addr_d;
  logic [15:0]      data_q, data_d;
  logic [15:0]      mask_q, mask_d;
  logic [15:0]      val_q, val_d;      // old value, then value written
  logic             err_q, err_d;
  logic             prst_q, prst_d;
  logic             den_q, den_d;
  logic             dwe_q, dwe_d;
  logic [15:0]      di_q, di_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lk_s1_q, lk_s2_q;
  logic [15:0]      wr_val;

  assign wr_val = (val_q & mask_q) | (data_q & ~mask_q);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    val_d   = val_q;
    err_d   = err_q;
    prst_d  = prst_q;
    den_d   = 1'b0;
    dwe_d   = 1'b0;
    di_d    = di_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          last_d  = bus.req_last;
          addr_d  = bus.req_addr;
          data_d  = bus.req_data;
          mask_d  = bus.req_mask;
          err_d   = 1'b0;
          den_d   = 1'b1;
          // a read mid-burst must leave pll_rst untouched
          if (bus.req_we) prst_d = 1'b1;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (drp_drdy) begin
          val_d   = drp_do;
          state_d = we_q ? S_MOD : S_RESP;
        end else if (cnt_q == CNT_W'(DRDY_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          prst_d  = 1'b0;
          state_d = S_RESP;
        end
      end
      S_MOD: begin
        val_d   = wr_val;
        di_d    = wr_val;
        den_d   = 1'b1;
        dwe_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_WR;
      end
      S_WR: begin
        if (drp_drdy) begin
          cnt_d   = '0;
          state_d = last_q ? S_HOLD : S_RESP;
        end else if (cnt_q == CNT_W'(DRDY_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          prst_d  = 1'b0;
          state_d = S_RESP;
        end
      end
      S_HOLD: begin
        // the DRDY cycle counts as the first hold cycle, so pll_rst drops
        // exactly RST_HOLD cycles after the write DRDY
        if (cnt_q == CNT_W'(RST_HOLD - 2)) begin
          prst_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_LOCKWAIT;
        end
      end
      S_LOCKWAIT: begin
        if (lk_s2_q) begin
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      val_q   <= '0;
      err_q   <= 1'b0;
      prst_q  <= 1'b0;
      den_q   <= 1'b0;
      dwe_q   <= 1'b0;
      di_q    <= '0;
      cnt_q   <= '0;
      lk_s1_q <= 1'b0;
      lk_s2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      val_q   <= val_d;
      err_q   <= err_d;
      prst_q  <= prst_d;
      den_q   <= den_d;
      dwe_q   <= dwe_d;
      di_q    <= di_d;
      cnt_q   <= cnt_d;
      lk_s1_q <= pll_locked;
      lk_s2_q <= lk_s1_q;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_data  = val_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state_q != S_IDLE) || prst_q;
  assign drp_daddr     = addr_q;
  assign drp_di        = di_q;
  assign drp_den       = den_q;
  assign drp_dwe       = dwe_q;
  assign pll_rst       = prst_q;

endmodule

// File: doc/pll_drp_ctrl.md
# pll_drp_ctrl

Reconfiguration controller for the clock generator's PLL_ADV dynamic reconfiguration port (DRP). It accepts single read or masked-write requests from a register-bank master and sequences DRP cycles. During a write burst it holds the PLL in reset, then releases it and waits for lock before signalling completion. It lets software retune the DDR/system/Ethernet clock outputs without a bitstream change.

## Interface
- LOCK_TIMEOUT, 65535: cycles to wait for synchronized lock after PLL reset release before flagging an error.
- RST_HOLD, 4: cycles pll_rst stays high after the last write's DRDY.
- DRDY_TIMEOUT, 63: cycles to wait for drp_drdy after a drp_den pulse.

Ports:
- sys_clk  in  1  controller clock; must not be derived from the PLL being reconfigured.
- sys_rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_we  in  1  1 = masked write, 0 = read.
- req_last  in  1  write ends the burst; triggers PLL release and lock wait.
- req_addr  in  5  DRP register address.
- req_data  in  16  write data.
- req_mask  in  16  1 = keep old bit, 0 = take req_data bit.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_data  out  16  read value (read) or value written (write).
- rsp_err  out  1  valid with rsp_valid; DRDY or lock timeout.
- busy  out  1  high whenever the FSM is not in IDLE or pll_rst is high.
- drp_daddr  out  5, drp_di  out  16, drp_den  out  1, drp_dwe  out  1: registered DRP drive.
- drp_do  in  16, drp_drdy  in  1: DRP return.
- pll_rst  out  1  PLL RST.
- pll_locked  in  1  PLL LOCKED, asynchronous; passes through a two-flop synchronizer internally.

## Operation
- States: IDLE, RD, MOD, WR, HOLD, LOCKWAIT, RESP.
- IDLE: a request is accepted when req_valid && req_ready. Address, data, mask, we and last are latched. A write also sets pll_rst=1 and leaves it set.
- RD: pulse drp_den=1 with drp_dwe=0 for one cycle, then wait for drp_drdy. On DRDY, latch drp_do. A read goes to RESP. A write goes to MOD.
- MOD: new = (old & mask) | (data & ~mask), 16-bit bitwise. Goes to WR.
- WR: pulse drp_den=1 and drp_dwe=1 for one cycle with drp_di=new, then wait for drp_drdy. If last=1, go to HOLD. Otherwise go to RESP, with pll_rst staying high for the next write.
- HOLD: count RST_HOLD cycles, then clear pll_rst and go to LOCKWAIT.
- LOCKWAIT: wait for the synchronized lock = 1, which gives rsp_err=0. If LOCK_TIMEOUT cycles elapse first, go to RESP with rsp_err=1.
- DRDY timeout: if drp_drdy does not arrive within DRDY_TIMEOUT cycles of the den pulse, go to RESP with rsp_err=1.
  - If a write burst was open, clear pll_rst.
  - Any late DRDY that arrives afterwards is ignored in IDLE.
- RESP: assert rsp_valid for one cycle, then return to IDLE.
- drp_drdy is ignored outside the RD and WR wait phases.
- A read issued while pll_rst is high (mid-burst) is allowed and does not change pll_rst.
- Reset: FSM goes to IDLE and all outputs go to 0, including pll_rst=0, so the PLL runs with its current DRP contents. Counters and the synchronizer clear. Reset takes effect mid-operation at any state.

## Timing
- Request accepted in cycle N: drp_den is high in N+1.
- DRDY sampled in cycle M:
  - read: rsp_valid in M+1;
  - write: second den in M+2, i.e. one MOD cycle in between.
- Non-last write: rsp_valid one cycle after the write DRDY.
- Last write:
  - pll_rst falls RST_HOLD cycles after the write DRDY;
  - rsp_valid follows one cycle after the synchronized lock is seen (at least 2 cycles after pll_locked rises);
  - the timeout counter starts when pll_rst falls.
- req_ready is combinational from state (high in IDLE only). The earliest back-to-back acceptance is the cycle after rsp_valid.
- drp_den and drp_dwe are never high for more than one consecutive cycle.

## Test plan
- Read addr 0x08 with DRDY after 3 cycles and drp_do=0x1234 -> one den pulse with dwe=0, rsp_data=0x1234, rsp_err=0; pll_rst stays 0.
- Write addr 0x0A, data 0xABCD, mask 0xFF00, old 0x5A5A, last=0 -> drp_di=0x5ACD, pll_rst=1 from the acceptance cycle, rsp_valid with rsp_data=0x5ACD, pll_rst still 1.
- Follow-up write with last=1 and pll_locked rising 100 cycles after pll_rst falls:
  - pll_rst falls exactly 4 cycles after the write DRDY;
  - rsp_valid 2-3 cycles after lock, with rsp_err=0.
- Last write with pll_locked held 0 -> rsp_err=1 after 65535 cycles in LOCKWAIT; pll_rst=0; IDLE afterwards.
- drp_drdy never asserted on a read -> rsp_err=1 after 63 cycles; a later stray DRDY causes no response.
- sys_rst asserted in LOCKWAIT, then in WR wait -> next cycle all outputs 0, req_ready=1; a subsequent read completes normally.
